// File: rtl/data_mem_resp.sv
// Word-organised data memory for the MEM stage: screened single-cycle reads/writes,
// self-clearing after reset, sticky error flag and saturating access counters.
module data_mem_resp #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  mem_ctrl_input,
    input  logic [31:0] address,
    input  logic [31:0] w_data,
    output logic [31:0] read_data,
    output logic        rd_valid,
    output logic        ready,
    output logic        err,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
);

    typedef enum logic {CLEAR, READY} state_t;

    state_t          state, next_state;
    logic [AW-1:0]   clr_idx;
    logic [31:0]     mem [DEPTH];

    logic [AW-1:0]   idx_p0;
    logic            is_rw_p0, aligned_p0, in_range_p0;
    logic            accept_p0, reject_p0, rd_acc_p0, wr_acc_p0;

    logic [31:0]     rd_data_p1;
    logic            vld_p1;
    logic            err_q;
    logic [15:0]     rd_cnt_q, wr_cnt_q;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // Stage p0: request screening
    always_comb begin
        idx_p0      = address[AW+1:2];
        is_rw_p0    = (mem_ctrl_input == 2'b01) || (mem_ctrl_input == 2'b10);
        aligned_p0  = (address[1:0] == 2'b00);
        in_range_p0 = ((address >> (AW + 2)) == 32'd0);
        accept_p0   = (state == READY) && is_rw_p0 && aligned_p0 && in_range_p0;
        reject_p0   = (mem_ctrl_input != 2'b00) && !accept_p0;
        rd_acc_p0   = accept_p0 && mem_ctrl_input[0];
        wr_acc_p0   = accept_p0 && mem_ctrl_input[1];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= CLEAR;
            clr_idx <= '0;
        end else begin
            state   <= next_state;
            if (state == CLEAR)
                clr_idx <= clr_idx + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        if (state == CLEAR && clr_idx == AW'(DEPTH - 1))
            next_state = READY;
    end

    // The clear sweep owns the write port until READY; requests never write during it
    always_ff @(posedge clk) begin
        if (state == CLEAR)
            mem[clr_idx] <= 32'd0;
        else if (wr_acc_p0)
            mem[idx_p0] <= w_data;
    end

    // Stage p1: registered response, flags and counters
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_p1 <= 32'd0;
            vld_p1     <= 1'b0;
            err_q      <= 1'b0;
            rd_cnt_q   <= 16'd0;
            wr_cnt_q   <= 16'd0;
        end else begin
            vld_p1 <= rd_acc_p0;
            if (rd_acc_p0)
                rd_data_p1 <= mem[idx_p0];
            else if (reject_p0)
                rd_data_p1 <= 32'd0;
            if (reject_p0)
                err_q <= 1'b1;
            if (rd_acc_p0)
                rd_cnt_q <= sat_inc(rd_cnt_q);
            if (wr_acc_p0)
                wr_cnt_q <= sat_inc(wr_cnt_q);
        end
    end

    assign read_data = rd_data_p1;
    assign rd_valid  = vld_p1;
    assign ready     = (state == READY);
    assign err       = err_q;
    assign rd_count  = rd_cnt_q;
    assign wr_count  = wr_cnt_q;

endmodule

// File: tb/tb_data_mem_resp.sv
// Bench for data_mem_resp (DEPTH=16): table-driven vectors, hand sequences for
// reset/clear corners, and a read-data scoreboard fed at request time.
module tb_data_mem_resp;

    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  mem_ctrl_input = 2'b00;
    logic [31:0] address = 32'd0;
    logic [31:0] w_data = 32'd0;
    logic [31:0] read_data;
    logic        rd_valid;
    logic        ready;
    logic        err;
    logic [15:0] rd_count;
    logic [15:0] wr_count;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] sb_q[$];

    data_mem_resp #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .reset(reset), .mem_ctrl_input(mem_ctrl_input),
        .address(address), .w_data(w_data), .read_data(read_data),
        .rd_valid(rd_valid), .ready(ready), .err(err),
        .rd_count(rd_count), .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  ctrl;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exp_rv;
        logic [31:0] exp_data;
        logic        exp_err;
        logic [15:0] exp_rd;
        logic [15:0] exp_wr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every completed read is matched against the oldest expected value
    always @(negedge clk) begin
        if (!reset && rd_valid) begin
            if (sb_q.size() == 0) begin
                chk("sb_unexpected_rd_valid", 32'd1, 32'd0);
            end else begin
                chk("sb_read_data", read_data, sb_q.pop_front());
            end
        end
    end

    // Present one request for one cycle; returns at the negedge after it was sampled
    task automatic step(input logic [1:0] c, input logic [31:0] a, input logic [31:0] d,
                        input logic push, input logic [31:0] exp);
        mem_ctrl_input = c;
        address        = a;
        w_data         = d;
        if (push) sb_q.push_back(exp);
        @(negedge clk);
        mem_ctrl_input = 2'b00;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (!ready && n < 4 * DEPTH) begin
            @(negedge clk);
            n++;
        end
        chk("wait_ready_timeout", {31'd0, ready}, 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        wait_ready();
    endtask

    task automatic check_ready_rise(input string tag);
        for (int i = 1; i < DEPTH; i++) begin
            @(posedge clk); #1;
            chk({tag, "_ready_low"}, {31'd0, ready}, 32'd0);
        end
        @(posedge clk); #1;
        chk({tag, "_ready_high"}, {31'd0, ready}, 32'd1);
        @(negedge clk);
    endtask

    vec_t vecs[16];

    initial begin
        vecs[0]  = '{2'b10, 32'h08,       32'hDEAD_BEEF, 1'b0, 32'h0,         1'b0, 16'd0, 16'd1};
        vecs[1]  = '{2'b01, 32'h08,       32'h0,         1'b1, 32'hDEAD_BEEF, 1'b0, 16'd1, 16'd1};
        vecs[2]  = '{2'b01, 32'h06,       32'h0,         1'b0, 32'h0,         1'b1, 16'd1, 16'd1};
        vecs[3]  = '{2'b00, 32'h08,       32'h0,         1'b0, 32'h0,         1'b1, 16'd1, 16'd1};
        vecs[4]  = '{2'b01, 32'h08,       32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1, 16'd2, 16'd1};
        vecs[5]  = '{2'b01, 32'h40,       32'h0,         1'b0, 32'h0,         1'b1, 16'd2, 16'd1};
        vecs[6]  = '{2'b01, 32'h08,       32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1, 16'd3, 16'd1};
        vecs[7]  = '{2'b11, 32'h08,       32'h1234_5678, 1'b0, 32'h0,         1'b1, 16'd3, 16'd1};
        vecs[8]  = '{2'b01, 32'h08,       32'h0,         1'b1, 32'hDEAD_BEEF, 1'b1, 16'd4, 16'd1};
        vecs[9]  = '{2'b00, 32'h0,        32'h0,         1'b0, 32'hDEAD_BEEF, 1'b1, 16'd4, 16'd1};
        vecs[10] = '{2'b10, 32'h3C,       32'hA5A5_0001, 1'b0, 32'hDEAD_BEEF, 1'b1, 16'd4, 16'd2};
        vecs[11] = '{2'b10, 32'h3D,       32'h1111_1111, 1'b0, 32'h0,         1'b1, 16'd4, 16'd2};
        vecs[12] = '{2'b10, 32'h100,      32'h2222_2222, 1'b0, 32'h0,         1'b1, 16'd4, 16'd2};
        vecs[13] = '{2'b01, 32'h3C,       32'h0,         1'b1, 32'hA5A5_0001, 1'b1, 16'd5, 16'd2};
        vecs[14] = '{2'b01, 32'h00,       32'h0,         1'b1, 32'h0,         1'b1, 16'd6, 16'd2};
        vecs[15] = '{2'b10, 32'h8000_0000, 32'h3333_3333, 1'b0, 32'h0,        1'b1, 16'd6, 16'd2};

        // Reset state and ready timing after release
        #2;
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_flags", {28'd0, rd_valid, ready, err, 1'b0}, 32'd0);
        chk("rst_counts", {rd_count, wr_count}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check_ready_rise("release");

        // Sweep: every word reads back zero, back to back
        for (int i = 0; i < DEPTH; i++)
            step(2'b01, 32'(i * 4), 32'd0, 1'b1, 32'd0);
        @(negedge clk);
        chk("sweep_err", {31'd0, err}, 32'd0);
        chk("sweep_rd_count", {16'd0, rd_count}, 32'(DEPTH));

        // Vector table from a clean reset
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].ctrl, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rv, vecs[i].exp_data);
            chk($sformatf("vec%0d_rd_valid", i), {31'd0, rd_valid}, {31'd0, vecs[i].exp_rv});
            chk($sformatf("vec%0d_read_data", i), read_data, vecs[i].exp_data);
            chk($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
            chk($sformatf("vec%0d_counts", i), {rd_count, wr_count}, {vecs[i].exp_rd, vecs[i].exp_wr});
        end

        // Write while still clearing is rejected and leaves memory zero
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        step(2'b10, 32'h04, 32'hFFFF_FFFF, 1'b0, 32'd0);
        chk("clr_write_err", {31'd0, err}, 32'd1);
        chk("clr_write_wr_count", {16'd0, wr_count}, 32'd0);
        wait_ready();
        step(2'b01, 32'h04, 32'd0, 1'b1, 32'd0);
        chk("clr_write_readback", read_data, 32'd0);
        chk("clr_write_rd_valid", {31'd0, rd_valid}, 32'd1);

        // Reset in the middle of the clear sweep restarts it
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        repeat (7) @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("midclr_outputs", {28'd0, rd_valid, ready, err, 1'b0}, 32'd0);
        chk("midclr_counts", {rd_count, wr_count}, 32'd0);
        chk("midclr_read_data", read_data, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check_ready_rise("midclr");

        // Read counter saturation
        do_reset();
        for (int i = 0; i < 65534; i++)
            step(2'b01, 32'h0, 32'd0, 1'b1, 32'd0);
        chk("sat_pre", {16'd0, rd_count}, 32'h0000_FFFE);
        for (int i = 0; i < 3; i++) begin
            step(2'b01, 32'h0, 32'd0, 1'b1, 32'd0);
            chk($sformatf("sat_rd_count_%0d", i), {16'd0, rd_count}, 32'h0000_FFFF);
        end
        chk("sat_wr_count", {16'd0, wr_count}, 32'd0);
        chk("sat_err", {31'd0, err}, 32'd0);

        @(negedge clk);
        @(negedge clk);
        chk("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Word-organised data memory that answers the MEM stage's data-memory requests on the processor's data-memory interface. It takes the stage's 2-bit control, byte address and store data, and returns load data one clock later. Every access is screened for alignment, range and legality. It also clears itself after reset and keeps saturating access counters for debug.

## Interface
Parameters:
- DEPTH, 256, number of 32-bit words; power of two, ≥ 4
- AW, 8, word-index width, equal to log2(DEPTH)

Ports:
- clk  input  1  single clock; all state changes on its rising edge
- reset  input  1  asynchronous, active-high reset
- mem_ctrl_input  input  2  bit1 = write, bit0 = read; 2'b00 = idle, 2'b11 = illegal
- address  input  32  byte address from the MEM stage
- w_data  input  32  store data, sampled with a write
- read_data  output  32  load data, registered
- rd_valid  output  1  high for one cycle when read_data holds a completed read
- ready  output  1  high once the post-reset clear has finished
- err  output  1  sticky error flag; cleared only by reset
- rd_count  output  16  number of accepted reads; saturates at 16'hFFFF
- wr_count  output  16  number of accepted writes; saturates at 16'hFFFF

## Operation
- Reset (asynchronous, takes effect immediately, independent of clk):
  - read_data = 0, rd_valid = 0, ready = 0, err = 0, rd_count = 0, wr_count = 0.
  - FSM goes to CLEAR with clear index = 0.
- FSM state CLEAR:
  - Each clock writes 0 to word[clear index], then increments the index.
  - The edge that clears word DEPTH-1 moves the FSM to READY and sets ready = 1.
  - A reset during CLEAR restarts the sweep from index 0.
- FSM state READY: serves requests. There is no exit from READY except reset.
- Word index = address[AW+1:2]. An access is accepted only if all of the following hold:
  - state is READY;
  - mem_ctrl_input is 2'b01 or 2'b10;
  - address[1:0] == 2'b00;
  - address < DEPTH*4 (all upper bits above AW+1 are zero).
- Accepted write: word[index] <= w_data at the edge; wr_count increments unless already saturated.
- Accepted read: read_data <= word[index] at the edge and rd_valid = 1 for the next cycle; rd_count increments unless already saturated.
- Rejected non-idle access:
  - Causes: 2'b11, misaligned, out of range, or any request while ready = 0.
  - No memory change and no count change.
  - read_data <= 0 and rd_valid stays 0.
  - err <= 1 (sticky).
- Idle (2'b00): read_data holds its last value, rd_valid = 0, no other change.
- A read at cycle N+1 to an address written at cycle N returns the new data, because the write has already landed at edge N.

## Timing
- Read latency: request presented in cycle N, data and rd_valid registered at edge N and visible during cycle N+1.
- Write takes effect at the request-cycle edge. No write response is returned.
- Back-to-back accesses, one per cycle, are sustained with no bubbles.
- ready rises exactly DEPTH clock edges after reset is released.
- err rises at the edge that samples the offending request.
- Counter saturation: once at 16'hFFFF, the counter stays there. The other counter is unaffected.

## Test plan
- Reset release with DEPTH=16 -> ready = 0 for 15 edges and 1 after the 16th; a read of every word then returns 32'h0000_0000 with rd_valid = 1 one cycle later; err = 0.
- Write 32'hDEAD_BEEF @ 0x8, then read 0x8 in the next cycle -> read_data = 32'hDEAD_BEEF in the following cycle; wr_count = 1, rd_count = 1.
- Read 0x6 (misaligned), then 0x40 with DEPTH=16 (out of range), then ctrl 2'b11 -> err = 1 after the first; read_data = 0; rd_valid stays 0; counts unchanged; memory unchanged.
- Write 0x4 while ready = 0 -> err = 1; after ready, read 0x4 returns 0.
- Assert reset mid-CLEAR at index 7, then release -> ready rises DEPTH edges after release, not earlier; all outputs are 0 during reset.
- Preload rd_count to 16'hFFFE via 65534 reads, then 3 more reads -> rd_count = 16'hFFFF and stays there; wr_count unchanged.
